uart_hex_sender: RTL and testbench
==================================

# uart_hex_sender

Serialises a captured group of hex/BCD nibbles into ASCII characters and feeds them one byte at a time to a `uart` transmitter through its `tx_start_triger` / `tx_data` / `tx_busy` handshake. It performs the inverse of `ascii_to_bcd`:

- nibble 0–9 → "0"–"9";
- nibble A–F → "A"–"F";
- optionally followed by CR LF.

It sits between the display/counter logic, which supplies the digits, and the `uart` instance, which drives `tx`.

## Interface
Parameters:
- `NUM_DIGITS`, 4, number of nibbles sent per request (1–8).
- `APPEND_CRLF`, 1, 1 = append 0x0D, 0x0A after the digits; 0 = digits only.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `send`  in  1  request; sampled every cycle, accepted only when `busy`=0.
- `digits`  in  4*NUM_DIGITS  nibbles; the most-significant nibble is sent first.
- `tx_busy`  in  1  from `uart` `tx_busy`.
- `tx_start`  out  1  one-cycle pulse to `uart` `tx_start_triger`.
- `tx_data`  out  8  ASCII byte to `uart` `tx_data`; held stable from pulse until `tx_busy` falls.
- `busy`  out  1  high from acceptance until the last byte completes.
- `done`  out  1  one-cycle pulse when the whole string has been sent.

## Operation
- **Reset values:** state IDLE; `tx_start`=0, `tx_data`=0x00, `busy`=0, `done`=0; the digit register and the character index are cleared.
- **Capture:** on `send`=1 in IDLE, register `digits`, set index=0, set `busy`=1, and go to LOAD. While `busy`=1, `send` is ignored and the `digits` input may change freely.
- **Character count:** `N = NUM_DIGITS + (APPEND_CRLF ? 2 : 0)`.
  - Index k < NUM_DIGITS selects nibble `NUM_DIGITS-1-k`.
  - Index `NUM_DIGITS` → 0x0D; index `NUM_DIGITS+1` → 0x0A.
- **Conversion (8-bit):**
  - nibble ≤ 9 → 0x30 + nibble;
  - nibble ≥ 10 → 0x41 + (nibble − 10).
- **State machine:**
  - IDLE → LOAD on an accepted `send`.
  - LOAD: `tx_data` ← char(index); next state FIRE.
  - FIRE: `tx_start`=1 for exactly this cycle; next state WAIT_HI.
  - WAIT_HI: stay until `tx_busy`=1, then go to WAIT_LO.
  - WAIT_LO: stay until `tx_busy`=0, then:
    - if index = N−1: pulse `done`, clear `busy`, go to IDLE;
    - otherwise: index+1, go to LOAD.
- **Stable data:** `tx_data` changes only in LOAD. The transmitter reads the byte bit-by-bit during its DATA phase, so it must not change earlier.
- **Already-busy transmitter:** if `tx_busy`=1 on entry to FIRE (transmitter occupied by another source), the block stays in LOAD and does not pulse until `tx_busy`=0.
- **Reset mid-string:** reset aborts immediately, and all outputs take their reset values. The partially sent string is not resumed.

## Timing
- Cycle 0: `send` is sampled high in IDLE.
- Cycle 1: LOAD, and `busy`=1.
- Cycle 2: `tx_start`=1 with `tx_data` valid.
- The `uart` raises `tx_busy` at cycle 3; WAIT_HI exits on that cycle.
- Inter-byte gap: 2 clk from `tx_busy` falling to the next `tx_start` (WAIT_LO→LOAD→FIRE).
- `done`: asserted the cycle after `tx_busy` falls on the last byte. `busy` drops in the same cycle as `done`.
- **Back-to-back requests:** `send` held high continuously restarts on the first IDLE cycle after `done`. There is no lost or duplicated request.
- Total time is approximately N × 10 bit periods of `uart` plus 3 clk per byte.

## Test plan
- **Basic string:** `digits`=16'h12AF, defaults, pulse `send` → `uart` `tx` emits 0x31, 0x32, 0x41, 0x46, 0x0D, 0x0A in order; exactly 6 `tx_start` pulses; one `done`; `busy` low afterwards.
- **Conversion boundaries:** `digits`=16'h09AF and 16'hF000 → bytes 0x30, 0x39, 0x41, 0x46 and 0x46, 0x30, 0x30, 0x30; a loopback `uart` `rx_data` matches each byte.
- **Request during transfer:** pulse `send` with 16'h1234, then pulse `send` with 16'h5678 mid-string → only "1234\r\n" is sent; no second `done`.
- **Reset mid-string:** assert `rst` during the 3rd byte → same cycle: `tx_start`=0, `tx_data`=0x00, `busy`=0. After release, a `send` of 16'h0001 transmits cleanly.
- **Parameter variant:** `APPEND_CRLF`=0, `NUM_DIGITS`=2, `digits`=8'hC3 → bytes 0x43, 0x33 only; `done` follows the second byte.
- **Continuous requests:** `send` held high → strings repeat back-to-back. Check the 2-clk inter-byte gap, that `tx_data` is stable across every `tx_busy`-high window, and that there are no `tx_start` pulses while `tx_busy`=1.

Source files
------------

// File: rtl/uart_hex_sender.sv
// uart_hex_sender: turns a captured group of hex nibbles into ASCII bytes
// (optionally followed by CR LF) and hands them one at a time to a UART
// transmitter over its start/data/busy handshake.
module uart_hex_sender #(
    parameter int NUM_DIGITS  = 4,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    send,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    busy,
    output logic                    done
);

    // Total characters per request, including the optional line ending.
    localparam int NCHARS = NUM_DIGITS + (APPEND_CRLF ? 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [4*NUM_DIGITS-1:0] dreg;   // shifted left one nibble per sent digit
    logic [3:0]              idx;
    logic [3:0]              nib;
    logic [7:0]              chr;
    logic                    last;

    assign nib      = dreg[4*NUM_DIGITS-1 -: 4];
    assign last     = (idx == 4'(NCHARS - 1));
    assign tx_start = (state == FIRE);

    // Character for the current index: hex digit, then CR, then LF.
    always_comb begin
        chr = 8'h0A;
        if (idx < 4'(NUM_DIGITS)) begin
            if (nib <= 4'd9) chr = 8'h30 + {4'h0, nib};
            else             chr = 8'h37 + {4'h0, nib};  // 0x41 + (nib - 10)
        end else if (idx == 4'(NUM_DIGITS)) begin
            chr = 8'h0D;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; LOAD holds off while the transmitter is occupied.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (send)     state_nx = LOAD;
            LOAD:    if (!tx_busy) state_nx = FIRE;
            FIRE:                  state_nx = WAIT_HI;
            WAIT_HI: if (tx_busy)  state_nx = WAIT_LO;
            WAIT_LO: if (!tx_busy) state_nx = last ? IDLE : LOAD;
            default:               state_nx = IDLE;
        endcase
    end

    // Datapath: capture, byte load (only in LOAD, so tx_data stays stable
    // across the whole transmission), index advance and completion flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dreg    <= '0;
            idx     <= '0;
            tx_data <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send) begin
                        dreg <= digits;
                        idx  <= '0;
                        busy <= 1'b1;
                    end
                end
                LOAD: tx_data <= chr;
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            idx  <= idx + 4'd1;
                            dreg <= dreg << 4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed bench for uart_hex_sender with a simple behavioural transmitter
// that raises busy the cycle after a start pulse and holds it a few cycles.
module tb_uart_hex_sender;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults (4 digits + CR LF)
    logic        send   = 1'b0;
    logic [15:0] digits = '0;
    logic        ub     = 1'b0;
    logic        ext    = 1'b0;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    assign tx_busy = ub | ext;

    // Instance B: 2 digits, no line ending
    logic        sendb = 1'b0;
    logic [7:0]  digb  = '0;
    logic        ubb   = 1'b0;
    logic        txb_start;
    logic [7:0]  txb_data;
    logic        busyb;
    logic        doneb;

    uart_hex_sender dut (
        .clk(clk), .rst(rst), .send(send), .digits(digits), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done)
    );

    uart_hex_sender #(.NUM_DIGITS(2), .APPEND_CRLF(1'b0)) dutb (
        .clk(clk), .rst(rst), .send(sendb), .digits(digb), .tx_busy(ubb),
        .tx_start(txb_start), .tx_data(txb_data), .busy(busyb), .done(doneb)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int   sa = 0, da = 0, db = 0;
    int   viol = 0, unst = 0, gbad = 0, gn = 0;
    int   cnt = 0, cntb = 0, cyc = 0, fall = 0;
    bit   fv = 1'b0;
    logic [7:0] lat = '0;

    // Transmitter model A plus protocol monitors (stability, gaps, overlap).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) da <= da + 1;
        if (rst) begin
            ub  <= 1'b0;
            cnt <= 0;
            fv  <= 1'b0;
        end else begin
            if (done) fv <= 1'b0;
            if (tx_start) begin
                sa  <= sa + 1;
                qa.push_back(tx_data);
                lat <= tx_data;
                ub  <= 1'b1;
                cnt <= 6;
                if (tx_busy) viol <= viol + 1;
                if (fv) begin
                    gn <= gn + 1;
                    if (cyc - fall != 3) gbad <= gbad + 1;
                end
            end else if (ub) begin
                if (tx_data !== lat) unst <= unst + 1;
                if (cnt == 0) begin
                    ub   <= 1'b0;
                    fall <= cyc;
                    fv   <= 1'b1;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // Transmitter model B.
    always @(posedge clk) begin
        if (doneb) db <= db + 1;
        if (rst) begin
            ubb  <= 1'b0;
            cntb <= 0;
        end else if (txb_start) begin
            qb.push_back(txb_data);
            ubb  <= 1'b1;
            cntb <= 4;
        end else if (ubb) begin
            if (cntb == 0) ubb <= 1'b0;
            else           cntb <= cntb - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // which: 0 = dones on A, 1 = starts on A, 2 = dones on B
    task automatic wait_for(input string tag, input int which, input int target);
        int v;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            v  = (which == 0) ? da : (which == 1) ? sa : db;
            ok = (v >= target);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic chk_q(input string tag, input logic [7:0] qq[$], input int off,
                         input logic [63:0] e, input int n);
        logic [31:0] got;
        for (int i = 0; i < n; i++) begin
            got = (off + i < qq.size()) ? 32'(qq[off + i]) : 32'h1FF;
            chk(tag, got, 32'(e[8*(n-1-i) +: 8]));
        end
    endtask

    task automatic send_a(input logic [15:0] d);
        @(negedge clk);
        digits = d;
        send   = 1'b1;
        @(negedge clk);
        send   = 1'b0;
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst tx_start", 32'(tx_start), 32'd0);
        chk("rst tx_data",  32'(tx_data),  32'h00);
        chk("rst busy",     32'(busy),     32'd0);
        chk("rst done",     32'(done),     32'd0);
        chk("rst b start",  32'(txb_start), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic string with cycle-exact start of the first byte
        digits = 16'h12AF;
        send   = 1'b1;
        @(negedge clk);                 // LOAD
        send   = 1'b0;
        digits = 16'hFFFF;              // must not affect the captured value
        chk("load busy",     32'(busy),     32'd1);
        chk("load no start", 32'(tx_start), 32'd0);
        @(negedge clk);                 // FIRE
        chk("fire start",    32'(tx_start), 32'd1);
        chk("fire data",     32'(tx_data),  32'h31);
        wait_for("basic done", 0, 1);
        chk("basic count", 32'(qa.size()), 32'd6);
        chk_q("basic byte", qa, 0, 64'h3132_4146_0D0A, 6);
        chk("basic starts", 32'(sa), 32'd6);
        chk("basic busy",   32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("basic dones",  32'(da), 32'd1);

        // Conversion boundaries
        qa.delete();
        send_a(16'h09AF);
        wait_for("bnd1 done", 0, 2);
        chk_q("bnd1 byte", qa, 0, 64'h3039_4146_0D0A, 6);
        qa.delete();
        send_a(16'hF000);
        wait_for("bnd2 done", 0, 3);
        chk_q("bnd2 byte", qa, 0, 64'h4630_3030_0D0A, 6);

        // Request during transfer is ignored
        qa.delete();
        base = sa;
        send_a(16'h1234);
        wait_for("mid starts", 1, base + 2);
        digits = 16'h5678;
        send   = 1'b1;
        @(negedge clk);
        send   = 1'b0;
        wait_for("mid done", 0, 4);
        repeat (100) @(negedge clk);
        chk("mid dones", 32'(da), 32'd4);
        chk("mid count", 32'(qa.size()), 32'd6);
        chk_q("mid byte", qa, 0, 64'h3132_3334_0D0A, 6);
        chk("mid busy", 32'(busy), 32'd0);

        // Reset during the third byte
        base = sa;
        send_a(16'hABCD);
        wait_for("rmid starts", 1, base + 3);
        rst = 1'b1;
        #1;
        chk("rmid tx_start", 32'(tx_start), 32'd0);
        chk("rmid tx_data",  32'(tx_data),  32'h00);
        chk("rmid busy",     32'(busy),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        qa.delete();
        send_a(16'h0001);
        wait_for("rmid done", 0, 5);
        chk_q("rmid byte", qa, 0, 64'h3030_3031_0D0A, 6);

        // Transmitter already occupied by another source
        qa.delete();
        ext  = 1'b1;
        base = sa;
        send_a(16'h0F0F);
        repeat (6) @(negedge clk);
        chk("ext no start", 32'(sa),   32'(base));
        chk("ext busy",     32'(busy), 32'd1);
        ext = 1'b0;
        wait_for("ext done", 0, 6);
        chk_q("ext byte", qa, 0, 64'h3046_3046_0D0A, 6);

        // Parameter variant: two digits, no CR LF
        @(negedge clk);
        digb  = 8'hC3;
        sendb = 1'b1;
        @(negedge clk);
        sendb = 1'b0;
        wait_for("b done", 2, 1);
        chk("b count", 32'(qb.size()), 32'd2);
        chk_q("b byte", qb, 0, 64'h4333, 2);
        chk("b busy", 32'(busyb), 32'd0);

        // Continuous requests: three strings back to back
        qa.delete();
        base   = sa;
        digits = 16'h5A0F;
        @(negedge clk);
        send = 1'b1;
        wait_for("cont done1", 0, 7);
        chk("cont restart1", 32'(busy), 32'd1);
        wait_for("cont done2", 0, 8);
        chk("cont restart2", 32'(busy), 32'd1);
        wait_for("cont last start", 1, base + 17);
        send = 1'b0;
        wait_for("cont done3", 0, 9);
        repeat (30) @(negedge clk);
        chk("cont dones", 32'(da), 32'd9);
        chk("cont busy",  32'(busy), 32'd0);
        chk("cont count", 32'(qa.size()), 32'd18);
        for (int k = 0; k < 3; k++)
            chk_q("cont byte", qa, 6 * k, 64'h3541_3046_0D0A, 6);

        // Protocol monitors
        chk("start while busy", 32'(viol), 32'd0);
        chk("data unstable",    32'(unst), 32'd0);
        chk("gap not 2",        32'(gbad), 32'd0);
        chk("gaps seen",        32'(gn > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
